// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - pipeline-side signal bundle for the interrupt controller
//
// Ports: none. The bundle carries the request, pipeline status and stack/fetch controls.
//   slave  : controller side (requests and status in, fetch/stack/vector controls out)
//   master : pipeline/driver side (directions reversed)
interface int_ctrl_if;
    logic        int_req;
    logic [2:0]  i_int_index;
    logic [31:0] i_pc;
    logic [3:0]  i_flag;
    logic        i_branch_pending;
    logic        i_rti;
    logic        o_fetch_en;
    logic        o_flush;
    logic        o_push_en;
    logic [31:0] o_push_data;
    logic [1:0]  o_pc_select;
    logic [2:0]  o_ivt_index;
    logic        o_int_ack;
    logic        o_in_isr;

    modport slave (
        input  int_req, i_int_index, i_pc, i_flag, i_branch_pending, i_rti,
        output o_fetch_en, o_flush, o_push_en, o_push_data, o_pc_select,
               o_ivt_index, o_int_ack, o_in_isr
    );

    modport master (
        output int_req, i_int_index, i_pc, i_flag, i_branch_pending, i_rti,
        input  o_fetch_en, o_flush, o_push_en, o_push_data, o_pc_select,
               o_ivt_index, o_int_ack, o_in_isr
    );
endinterface

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - single-level interrupt controller: drain, push PC/flags, vector
//
// Ports:
//   clk    : pipeline clock, rising edge
//   rst    : synchronous active-high reset
//   if_bus : int_ctrl_if.slave - int_req/i_int_index request, i_pc/i_flag state to save,
//            i_branch_pending/i_rti pipeline status; o_fetch_en/o_flush/o_push_*/
//            o_pc_select/o_ivt_index/o_int_ack/o_in_isr controls.
// Build option: INT_SAVE_FLAGS_EN adds the PUSH_FLAG state and flag capture.
//
// All outputs are registers loaded from the current state, so each state's outputs
// appear in the cycle after that state is occupied. This gives the int_req-to-ack
// latency of 4 cycles (3 without flag saving).
module int_ctrl (
    input  logic      clk,
    input  logic      rst,
    int_ctrl_if.slave if_bus
);

`ifdef INT_SAVE_FLAGS_EN
    typedef enum logic [2:0] {IDLE, DRAIN, PUSH_PC, PUSH_FLAG, VECTOR} state_t;
`else
    typedef enum logic [2:0] {IDLE, DRAIN, PUSH_PC, VECTOR} state_t;
`endif

    state_t      r_state;
    logic        r_pending;
    logic [2:0]  r_pend_index;
    logic [2:0]  r_vec_index;
    logic [31:0] r_pc;
    logic        r_in_isr;
`ifdef INT_SAVE_FLAGS_EN
    logic [3:0]  r_flag;
`else
    logic        w_unused_flag;
    assign w_unused_flag = ^if_bus.i_flag;
`endif

    logic        r_fetch_en;
    logic        r_flush;
    logic        r_push_en;
    logic [31:0] r_push_data;
    logic [1:0]  r_pc_select;
    logic [2:0]  r_ivt_index;
    logic        r_int_ack;

    logic        w_start;
    logic        w_take;

    // IDLE may begin servicing; w_take marks the edge that enters PUSH_PC.
    assign w_start = (r_state == IDLE) && r_pending && !r_in_isr;
    assign w_take  = !if_bus.i_branch_pending && (w_start || (r_state == DRAIN));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pending    <= 1'b0;
            r_pend_index <= 3'd0;
            r_vec_index  <= 3'd0;
            r_pc         <= 32'd0;
            r_in_isr     <= 1'b0;
`ifdef INT_SAVE_FLAGS_EN
            r_flag       <= 4'd0;
`endif
            r_fetch_en   <= 1'b1;
            r_flush      <= 1'b0;
            r_push_en    <= 1'b0;
            r_push_data  <= 32'd0;
            r_pc_select  <= 2'b00;
            r_ivt_index  <= 3'd0;
            r_int_ack    <= 1'b0;
        end else begin
            // One-deep latch: a new request merges and overwrites the slot, and
            // wins over the clear on the PUSH_PC entry edge.
            if (if_bus.int_req) begin
                r_pending    <= 1'b1;
                r_pend_index <= if_bus.i_int_index;
            end else if (w_take) begin
                r_pending    <= 1'b0;
            end

            // Clearing an already-clear flag is a no-op, so a stray RTI is harmless.
            if (if_bus.i_rti) begin
                r_in_isr <= 1'b0;
            end

            // The slot being serviced is frozen here so a coincident request
            // only affects the next service.
            if (w_take) begin
                r_pc        <= if_bus.i_pc;
                r_vec_index <= r_pend_index;
`ifdef INT_SAVE_FLAGS_EN
                r_flag      <= if_bus.i_flag;
`endif
            end

            r_fetch_en  <= 1'b0;
            r_flush     <= 1'b0;
            r_push_en   <= 1'b0;
            r_push_data <= 32'd0;
            r_pc_select <= 2'b00;
            r_ivt_index <= 3'd0;
            r_int_ack   <= 1'b0;

            case (r_state)
                IDLE: begin
                    r_fetch_en <= 1'b1;
                    if (w_start) begin
                        r_state <= if_bus.i_branch_pending ? DRAIN : PUSH_PC;
                    end
                end
                DRAIN: begin
                    if (!if_bus.i_branch_pending) begin
                        r_state <= PUSH_PC;
                    end
                end
                PUSH_PC: begin
                    r_push_en   <= 1'b1;
                    r_push_data <= r_pc;
                    r_flush     <= 1'b1;
`ifdef INT_SAVE_FLAGS_EN
                    r_state     <= PUSH_FLAG;
`else
                    r_state     <= VECTOR;
`endif
                end
`ifdef INT_SAVE_FLAGS_EN
                PUSH_FLAG: begin
                    r_push_en   <= 1'b1;
                    r_push_data <= {28'd0, r_flag};
                    r_flush     <= 1'b1;
                    r_state     <= VECTOR;
                end
`endif
                VECTOR: begin
                    r_pc_select <= 2'b01;
                    r_fetch_en  <= 1'b1;
                    r_flush     <= 1'b1;
                    r_int_ack   <= 1'b1;
                    r_ivt_index <= r_vec_index;
                    r_in_isr    <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign if_bus.o_fetch_en  = r_fetch_en;
    assign if_bus.o_flush     = r_flush;
    assign if_bus.o_push_en   = r_push_en;
    assign if_bus.o_push_data = r_push_data;
    assign if_bus.o_pc_select = r_pc_select;
    assign if_bus.o_ivt_index = r_ivt_index;
    assign if_bus.o_int_ack   = r_int_ack;
    assign if_bus.o_in_isr    = r_in_isr;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   req_cyc;

`ifdef INT_SAVE_FLAGS_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    int_ctrl_if u_if ();

    int_ctrl u_dut (
        .clk    (clk),
        .rst    (rst),
        .if_bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic fetch, input logic flush,
                              input logic push, input logic [31:0] data, input logic [1:0] sel,
                              input logic [2:0] ivt, input logic ack, input logic isr);
        check({tag, ".fetch_en"},  u_if.o_fetch_en,  fetch);
        check({tag, ".flush"},     u_if.o_flush,     flush);
        check({tag, ".push_en"},   u_if.o_push_en,   push);
        check({tag, ".push_data"}, u_if.o_push_data, data);
        check({tag, ".pc_select"}, u_if.o_pc_select, sel);
        check({tag, ".ivt_index"}, u_if.o_ivt_index, ivt);
        check({tag, ".int_ack"},   u_if.o_int_ack,   ack);
        check({tag, ".in_isr"},    u_if.o_in_isr,    isr);
    endtask

    task automatic expect_idle(input string tag, input logic isr);
        expect_out(tag, 1'b1, 1'b0, 1'b0, 32'd0, 2'b00, 3'd0, 1'b0, isr);
    endtask

    task automatic expect_push(input string tag, input logic [31:0] data);
        expect_out(tag, 1'b0, 1'b1, 1'b1, data, 2'b00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic expect_vector(input string tag, input logic [2:0] ivt);
        expect_out(tag, 1'b1, 1'b1, 1'b0, 32'd0, 2'b01, ivt, 1'b1, 1'b1);
    endtask

    task automatic do_rti(input string tag);
        u_if.i_rti = 1'b1;
        tick();
        u_if.i_rti = 1'b0;
        expect_idle(tag, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        req_cyc  = 0;
        rst                  = 1'b1;
        u_if.int_req         = 1'b0;
        u_if.i_int_index     = 3'd0;
        u_if.i_pc            = 32'd0;
        u_if.i_flag          = 4'd0;
        u_if.i_branch_pending = 1'b0;
        u_if.i_rti           = 1'b0;

        // Reset held, then released.
        tick();
        expect_idle("rst_hold0", 1'b0);
        tick();
        expect_idle("rst_hold1", 1'b0);
        rst = 1'b0;
        tick();
        expect_idle("rst_release", 1'b0);

        // Basic service: index 3, PC 0x40, flags 1010.
        u_if.int_req = 1'b1; u_if.i_int_index = 3'd3;
        u_if.i_pc = 32'h40; u_if.i_flag = 4'b1010;
        tick();
        req_cyc = cyc;
        u_if.int_req = 1'b0;
        expect_idle("t1_req", 1'b0);
        tick();
        u_if.i_pc = 32'h99; u_if.i_flag = 4'b0000;
        expect_idle("t1_enter", 1'b0);
        tick();
        expect_push("t1_push_pc", 32'h40);
`ifdef INT_SAVE_FLAGS_EN
        tick();
        expect_push("t1_push_flag", 32'hA);
`endif
        tick();
        expect_vector("t1_vector", 3'd3);
        check("t1_latency", cyc - req_cyc, LAT);
        tick();
        expect_idle("t1_post", 1'b1);

        // Second request while in the ISR waits for RTI.
        u_if.int_req = 1'b1; u_if.i_int_index = 3'd5;
        u_if.i_pc = 32'h100; u_if.i_flag = 4'b0101;
        tick();
        u_if.int_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_hold.push_en", u_if.o_push_en, 1'b0);
            check("t2_hold.in_isr", u_if.o_in_isr, 1'b1);
        end
        do_rti("t2_rti");
        tick();
        expect_idle("t2_enter", 1'b0);
        tick();
        expect_push("t2_push_pc", 32'h100);
`ifdef INT_SAVE_FLAGS_EN
        tick();
        expect_push("t2_push_flag", 32'h5);
`endif
        tick();
        expect_vector("t2_vector", 3'd5);
        do_rti("t2_end");

        // Branch pending for three sampled edges: drain, then normal sequence.
        u_if.i_branch_pending = 1'b1;
        u_if.int_req = 1'b1; u_if.i_int_index = 3'd2;
        u_if.i_pc = 32'h1F0; u_if.i_flag = 4'b0011;
        tick();
        u_if.int_req = 1'b0;
        expect_idle("t3_req", 1'b0);
        tick();
        expect_idle("t3_to_drain", 1'b0);
        tick();
        expect_out("t3_drain", 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        u_if.i_branch_pending = 1'b0;
        u_if.i_pc = 32'h200;
        tick();
        expect_out("t3_drain_exit", 1'b0, 1'b0, 1'b0, 32'd0, 2'b00, 3'd0, 1'b0, 1'b0);
        tick();
        expect_push("t3_push_pc", 32'h200);
`ifdef INT_SAVE_FLAGS_EN
        tick();
        expect_push("t3_push_flag", 32'h3);
`endif
        tick();
        expect_vector("t3_vector", 3'd2);
        do_rti("t3_end");

        // Request coincident with entry into PUSH_PC stays pending until after RTI.
        u_if.int_req = 1'b1; u_if.i_int_index = 3'd1;
        u_if.i_pc = 32'h300; u_if.i_flag = 4'b1100;
        tick();
        u_if.i_int_index = 3'd6;
        expect_idle("t4_req", 1'b0);
        tick();
        u_if.int_req = 1'b0;
        u_if.i_pc = 32'h400; u_if.i_flag = 4'b0110;
        expect_idle("t4_enter", 1'b0);
        tick();
        expect_push("t4_push_pc", 32'h300);
`ifdef INT_SAVE_FLAGS_EN
        tick();
        expect_push("t4_push_flag", 32'hC);
`endif
        tick();
        expect_vector("t4_vector", 3'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_hold.push_en", u_if.o_push_en, 1'b0);
            check("t4_hold.in_isr", u_if.o_in_isr, 1'b1);
        end
        do_rti("t4_rti");
        tick();
        expect_idle("t4_reenter", 1'b0);
        tick();
        expect_push("t4_push_pc2", 32'h400);
`ifdef INT_SAVE_FLAGS_EN
        tick();
        expect_push("t4_push_flag2", 32'h6);
`endif
        tick();
        expect_vector("t4_vector2", 3'd6);
        do_rti("t4_end");

        // RTI with no ISR active is ignored.
        do_rti("t6_stray_rti");
        tick();
        expect_idle("t6_after", 1'b0);

        // Reset while in PUSH_PC aborts the sequence and drops the request.
        u_if.int_req = 1'b1; u_if.i_int_index = 3'd4;
        u_if.i_pc = 32'h500; u_if.i_flag = 4'b1111;
        tick();
        u_if.int_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle("t5_rst", 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_idle("t5_after", 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
